nn_inference_sequencer: RTL and testbench

- Downstream consumer of the SDRAM/PCIe bus bridge: drives the bridge's get_data/which_data request port and consumes image_data/coeff_data.
- Runs a 3-layer fully-connected network (64→16→8→10) with a serial 16x16 MAC, one multiply per cycle.
- Reports all 10 output scores and the argmax class.
- Sits between the bus bridge and the result/display logic in the neural_network top level.

---
 rtl/nn_inference_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_nn_inference_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_inference_sequencer.sv
// Serial 3-layer fully-connected inference engine fed by the bus bridge (64->16->8->10, one MAC/cycle).
// Define NN_SATURATE_EN to saturate write-back results; otherwise they wrap to 16 bits.
module nn_inference_sequencer #(
  parameter int unsigned N0     = 64,
  parameter int unsigned N1     = 16,
  parameter int unsigned N2     = 8,
  parameter int unsigned N3     = 10,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned LBITS  = 2,
  parameter int unsigned IMSIZE = 128,
  parameter int unsigned CSIZE  = 2496
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  get_data,
  output logic [LBITS-1:0]      which_data,
  input  logic                  busy,
  input  logic [IMSIZE*8-1:0]   image_data,
  input  logic [CSIZE*8-1:0]    coeff_data,
  output logic                  seq_busy,
  output logic                  done,
  output logic [N3*16-1:0]      scores,
  output logic [3:0]            result_class
);

  localparam int unsigned IW = $clog2(N0);
  localparam int unsigned OW = $clog2((N1 > N3) ? N1 : N3);
  localparam int unsigned NW = CSIZE / 2;
  localparam int unsigned WW = $clog2(NW);

  typedef enum logic [3:0] {
    StIdle, StReq, StWaitAck, StWaitDone, StLoadImg, StMac, StWb, StArgmax, StFinish
  } state_e;

  state_e             state;
  logic [LBITS-1:0]   layer;
  logic [IW-1:0]      in_cnt;
  logic [OW-1:0]      out_cnt;
  logic [3:0]         arg_cnt;
  logic signed [39:0] acc;
  logic [3:0]         best_idx;
  logic signed [15:0] best_val;

  logic signed [15:0] act_a   [N0];
  logic signed [15:0] act_b   [N1];
  logic signed [15:0] score_q [N3];

  logic signed [15:0] coeff_w [NW];
  logic signed [15:0] img_w   [N0];

  for (genvar k = 0; k < NW; k++) begin : g_coeff
    assign coeff_w[k] = coeff_data[16*k +: 16];
  end

  for (genvar k = 0; k < N0; k++) begin : g_img
    assign img_w[k] = image_data[16*k +: 16];
  end

  logic [IW-1:0]      n_in_m1;
  logic [OW-1:0]      n_out_m1;
  logic [WW-1:0]      w_idx;
  logic signed [15:0] w_cur;
  logic signed [15:0] a_cur;
  logic signed [31:0] prod;
  logic signed [39:0] acc_sum;
  logic signed [39:0] shifted;
  logic signed [15:0] wb_val;
  logic signed [15:0] wb_relu;
  logic signed [15:0] cand;
  logic               take;
  logic [3:0]         best_idx_next;

  always_comb begin
    case (layer)
      LBITS'(1): begin
        n_in_m1  = IW'(N0 - 1);
        n_out_m1 = OW'(N1 - 1);
      end
      LBITS'(2): begin
        n_in_m1  = IW'(N1 - 1);
        n_out_m1 = OW'(N2 - 1);
      end
      default: begin
        n_in_m1  = IW'(N2 - 1);
        n_out_m1 = OW'(N3 - 1);
      end
    endcase
  end

  // Weights of output o are stored contiguously: halfword o*N_in + i.
  always_comb begin
    w_idx   = WW'(out_cnt) * (WW'(n_in_m1) + WW'(1)) + WW'(in_cnt);
    w_cur   = coeff_w[w_idx];
    a_cur   = act_a[in_cnt];
    prod    = 32'(a_cur) * 32'(w_cur);
    acc_sum = ((in_cnt == '0) ? 40'sd0 : acc) + 40'(prod);
  end

  always_comb begin
    shifted = acc >>> FRAC;
`ifdef NN_SATURATE_EN
    if (shifted > 40'sd32767) begin
      wb_val = 16'sh7fff;
    end else if (shifted < -40'sd32768) begin
      wb_val = 16'sh8000;
    end else begin
      wb_val = shifted[15:0];
    end
`else
    wb_val = shifted[15:0];
`endif
    wb_relu = wb_val[15] ? 16'sd0 : wb_val;
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    cand          = score_q[arg_cnt];
    take          = (arg_cnt == 4'd0) || (cand > best_val);
    best_idx_next = take ? arg_cnt : best_idx;
  end

  always_comb begin
    scores = '0;
    for (int k = 0; k < N3; k++) begin
      scores[16*k +: 16] = score_q[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      layer        <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      arg_cnt      <= '0;
      acc          <= '0;
      best_idx     <= '0;
      best_val     <= '0;
      get_data     <= 1'b0;
      which_data   <= '0;
      seq_busy     <= 1'b0;
      done         <= 1'b0;
      result_class <= '0;
      for (int k = 0; k < N0; k++) act_a[k] <= '0;
      for (int k = 0; k < N1; k++) act_b[k] <= '0;
      for (int k = 0; k < N3; k++) score_q[k] <= '0;
    end else begin
      get_data <= 1'b0;
      done     <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            layer      <= '0;
            which_data <= '0;
            get_data   <= 1'b1;
            seq_busy   <= 1'b1;
            state      <= StReq;
          end
        end
        StReq: state <= StWaitAck;
        StWaitAck: begin
          if (busy) state <= StWaitDone;
        end
        StWaitDone: begin
          if (!busy) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            state   <= (layer == '0) ? StLoadImg : StMac;
          end
        end
        StLoadImg: begin
          for (int k = 0; k < N0; k++) act_a[k] <= img_w[k];
          layer      <= LBITS'(1);
          which_data <= LBITS'(1);
          get_data   <= 1'b1;
          state      <= StReq;
        end
        StMac: begin
          acc <= acc_sum;
          if (in_cnt == n_in_m1) begin
            state <= StWb;
          end else begin
            in_cnt <= in_cnt + IW'(1);
          end
        end
        StWb: begin
          in_cnt <= '0;
          if (layer == LBITS'(3)) begin
            score_q[out_cnt] <= wb_val;
          end else begin
            act_b[out_cnt] <= wb_relu;
          end
          if (out_cnt != n_out_m1) begin
            out_cnt <= out_cnt + OW'(1);
            state   <= StMac;
          end else if (layer != LBITS'(3)) begin
            // Forward the hidden layer, folding in the value being written this cycle.
            for (int k = 0; k < N1; k++) begin
              act_a[k] <= (OW'(k) == out_cnt) ? wb_relu : act_b[k];
            end
            layer      <= layer + LBITS'(1);
            which_data <= layer + LBITS'(1);
            get_data   <= 1'b1;
            state      <= StReq;
          end else begin
            arg_cnt <= '0;
            state   <= StArgmax;
          end
        end
        StArgmax: begin
          if (take) begin
            best_val <= cand;
            best_idx <= arg_cnt;
          end
          if (arg_cnt == 4'(N3 - 1)) begin
            result_class <= best_idx_next;
            done         <= 1'b1;
            seq_busy     <= 1'b0;
            state        <= StFinish;
          end else begin
            arg_cnt <= arg_cnt + 4'd1;
          end
        end
        StFinish: state <= StIdle;
        default:  state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Randomized and directed bench for nn_inference_sequencer with a bus-bridge model and an
// arithmetic reference network.
module tb_nn_inference_sequencer;

  localparam int unsigned FRAC = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           get_data;
  logic [1:0]     which_data;
  logic           busy;
  logic [1023:0]  image_data;
  logic [19967:0] coeff_data;
  logic           seq_busy;
  logic           done;
  logic [159:0]   scores;
  logic [3:0]     result_class;

  nn_inference_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .get_data     (get_data),
    .which_data   (which_data),
    .busy         (busy),
    .image_data   (image_data),
    .coeff_data   (coeff_data),
    .seq_busy     (seq_busy),
    .done         (done),
    .scores       (scores),
    .result_class (result_class)
  );

  always #5 clk = ~clk;

  logic signed [15:0] pix [64];
  logic signed [15:0] w1  [1024];
  logic signed [15:0] w2  [128];
  logic signed [15:0] w3  [80];
  logic signed [15:0] exp_s [10];
  int                 exp_class;

  int n_tests = 0;
  int n_fail  = 0;
  int wd_log[$];
  int proto_err;
  int done_cnt;
  int br_cnt;
  int br_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_coeff(input int sel);
    coeff_data = '0;
    if (sel == 1) for (int j = 0; j < 1024; j++) coeff_data[16*j +: 16] = w1[j];
    if (sel == 2) for (int j = 0; j < 128; j++)  coeff_data[16*j +: 16] = w2[j];
    if (sel == 3) for (int j = 0; j < 80; j++)   coeff_data[16*j +: 16] = w3[j];
  endtask

  // Bridge model: busy rises 2 cycles after get_data and falls 5 cycles later.
  initial begin
    busy   = 1'b0;
    br_cnt = 0;
    br_sel = 0;
    forever begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      if (reset) begin
        br_cnt = 0;
        busy   = 1'b0;
      end else begin
        if (get_data) begin
          if (br_cnt != 0) proto_err++;
          else begin
            wd_log.push_back(int'(which_data));
            br_sel = int'(which_data);
          end
        end
        if (br_cnt != 0 || get_data) begin
          br_cnt++;
          if (br_cnt == 3) begin
            busy = 1'b1;
            load_coeff(br_sel);
          end
          if (br_cnt == 8) begin
            busy   = 1'b0;
            br_cnt = 0;
          end
        end
      end
    end
  end

  function automatic logic signed [15:0] fix(input longint acc, input bit relu);
    longint             r;
    logic signed [15:0] v;
    r = acc >>> FRAC;
`ifdef NN_SATURATE_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    v = r[15:0];
    if (relu && v < 0) v = 0;
    return v;
  endfunction

  task automatic compute_expected();
    logic signed [15:0] a1 [16];
    logic signed [15:0] a2 [8];
    longint acc;
    for (int o = 0; o < 16; o++) begin
      acc = 0;
      for (int i = 0; i < 64; i++) acc += longint'(pix[i]) * longint'(w1[o*64+i]);
      a1[o] = fix(acc, 1'b1);
    end
    for (int o = 0; o < 8; o++) begin
      acc = 0;
      for (int i = 0; i < 16; i++) acc += longint'(a1[i]) * longint'(w2[o*16+i]);
      a2[o] = fix(acc, 1'b1);
    end
    for (int o = 0; o < 10; o++) begin
      acc = 0;
      for (int i = 0; i < 8; i++) acc += longint'(a2[i]) * longint'(w3[o*8+i]);
      exp_s[o] = fix(acc, 1'b0);
    end
    exp_class = 0;
    for (int k = 1; k < 10; k++) if (exp_s[k] > exp_s[exp_class]) exp_class = k;
  endtask

  task automatic fill_all(input logic [15:0] pv, input logic [15:0] wv);
    for (int j = 0; j < 64; j++)   pix[j] = pv;
    for (int j = 0; j < 1024; j++) w1[j] = wv;
    for (int j = 0; j < 128; j++)  w2[j] = wv;
    for (int j = 0; j < 80; j++)   w3[j] = wv;
  endtask

  function automatic logic [15:0] rnd(input int span);
    int v;
    v = int'($urandom_range(0, 2 * span - 1)) - span;
    return v[15:0];
  endfunction

  task automatic rand_fill(input int span);
    for (int j = 0; j < 64; j++)   pix[j] = rnd(span);
    for (int j = 0; j < 1024; j++) w1[j] = rnd(span);
    for (int j = 0; j < 128; j++)  w2[j] = rnd(span);
    for (int j = 0; j < 80; j++)   w3[j] = rnd(span);
  endtask

  task automatic prepare();
    compute_expected();
    for (int j = 0; j < 64; j++) image_data[16*j +: 16] = pix[j];
    wd_log.delete();
    proto_err = 0;
    done_cnt  = 0;
  endtask

  task automatic run_inference(input string name, input bit extra_start);
    int cyc;
    int k;
    prepare();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, "_seq_busy_hi"}, 32'(seq_busy), 32'd1);
    cyc = 0;
    k   = 0;
    while (!done && cyc < 6000) begin
      if (extra_start && wd_log.size() == 2 && br_cnt == 0) k++;
      start = (k == 10);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check({name, "_done_seen"}, 32'(done), 32'd1);
    if (done) begin
      for (int s = 0; s < 10; s++) begin
        check($sformatf("%s_score%0d", name, s), 32'(scores[16*s +: 16]),
              32'($unsigned(exp_s[s])));
      end
      check({name, "_class"}, 32'(result_class), 32'(exp_class));
    end
    repeat (5) @(posedge clk);
    #1;
    check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({name, "_req_count"}, 32'(wd_log.size()), 32'd4);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("%s_which%0d", name, s),
            32'((s < wd_log.size()) ? wd_log[s] : 255), 32'(s));
    end
    check({name, "_protocol"}, 32'(proto_err), 32'd0);
    check({name, "_seq_busy_lo"}, 32'(seq_busy), 32'd0);
  endtask

  initial begin
    int cyc;
    reset      = 1'b1;
    start      = 1'b0;
    image_data = '0;
    coeff_data = '0;
    proto_err  = 0;
    done_cnt   = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_get_data", 32'(get_data), 32'd0);
    check("rst_which", 32'(which_data), 32'd0);
    check("rst_seq_busy", 32'(seq_busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_scores", 32'(scores[31:0] | scores[159:128]), 32'd0);
    check("rst_class", 32'(result_class), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    fill_all(16'h0000, 16'h0000);
    pix[0] = 16'sh0100;
    for (int o = 0; o < 16; o++) w1[o*64] = 16'sh0100;
    for (int o = 0; o < 8; o++)  w2[o*16] = 16'sh0100;
    for (int o = 0; o < 10; o++) w3[o*8]  = 16'sh0100;
    run_inference("identity", 1'b0);
    check("identity_score_lit", 32'(scores[15:0]), 32'h0100);

    w3[7*8] = 16'sh0300;
    run_inference("argmax", 1'b0);
    check("argmax_class_lit", 32'(result_class), 32'd7);

    fill_all(16'h7fff, 16'h7fff);
    run_inference("max_vals", 1'b0);

    for (int j = 0; j < 1024; j++) w1[j] = 16'sh8001;
    run_inference("neg_l1", 1'b0);

    for (int t = 0; t < 4; t++) begin
      rand_fill((t == 3) ? 32768 : 256);
      run_inference($sformatf("rand%0d", t), 1'b0);
    end

    // Abort during the layer-2 transfer, then confirm a clean rerun.
    rand_fill(256);
    prepare();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!(wd_log.size() == 3 && busy) && cyc < 6000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("midrst_reached", 32'(cyc < 6000), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_get_data", 32'(get_data), 32'd0);
    check("midrst_seq_busy", 32'(seq_busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_inference("post_rst", 1'b0);

    rand_fill(128);
    run_inference("extra_start", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
